// File: rtl/spi_reg_pkg.sv
// Shared address map defaults for the SPI register bridge and its neighbours.
package spi_reg_pkg;

    localparam int unsigned SpiDw = 96;
    localparam int unsigned SpiAw = 7;

    localparam logic [6:0] SpiBaseAddr  = 7'h70;
    localparam logic [6:0] SpiRdCntAddr = 7'h7E;
    localparam logic [6:0] SpiWrCntAddr = 7'h7F;

    typedef enum logic [1:0] {
        AddrGen,
        AddrRdCnt,
        AddrWrCnt,
        AddrNone
    } addr_kind_e;

endpackage

// File: rtl/sync_pulse.sv
// Multi-stage synchroniser followed by a registered rising-edge detector.
module sync_pulse #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              pulse_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d};
            prev_q  <= sync_q[STAGES-1];
            pulse_q <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-to-register bridge: synchronised request strobes, general registers and
// read/write transaction counters behind a small address decoder.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned    DW          = SpiDw,
    parameter int unsigned    AW          = SpiAw,
    parameter int unsigned    NUM_REGS    = 4,
    parameter logic [AW-1:0]  BASE_ADDR   = AW'(SpiBaseAddr),
    parameter logic [AW-1:0]  RD_CNT_ADDR = AW'(SpiRdCntAddr),
    parameter logic [AW-1:0]  WR_CNT_ADDR = AW'(SpiWrCntAddr),
    parameter logic [DW-1:0]  RESET_VAL   = '0,
    parameter int unsigned    SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spi_re,
    input  logic                   spi_we,
    input  logic [AW-1:0]          addr,
    input  logic [DW-1:0]          wdat,
    output logic [DW-1:0]          rdat,
    output logic [NUM_REGS*DW-1:0] regs,
    output logic [DW-1:0]          rd_count,
    output logic [DW-1:0]          wr_count,
    output logic                   rd_stb,
    output logic                   wr_stb,
    output logic                   addr_err
);

    localparam int unsigned BaseInt = 32'(BASE_ADDR);
    localparam int unsigned TopInt  = BaseInt + NUM_REGS - 1;
    localparam int unsigned RdInt   = 32'(RD_CNT_ADDR);
    localparam int unsigned WrInt   = 32'(WR_CNT_ADDR);
    localparam int unsigned MaxAddr = (32'd1 << AW) - 1;

    if (NUM_REGS < 1 || SYNC_STAGES < 2 || TopInt > MaxAddr || RdInt == WrInt ||
        (RdInt >= BaseInt && RdInt <= TopInt) ||
        (WrInt >= BaseInt && WrInt <= TopInt)) begin : g_param_err
        $error("spi_reg_bank: invalid parameters or overlapping address map");
    end

    sync_pulse #(
        .STAGES (SYNC_STAGES)
    ) u_sync_re (
        .clk   (clk),
        .reset (reset),
        .d     (spi_re),
        .pulse (rd_stb)
    );

    sync_pulse #(
        .STAGES (SYNC_STAGES)
    ) u_sync_we (
        .clk   (clk),
        .reset (reset),
        .d     (spi_we),
        .pulse (wr_stb)
    );

    logic [DW-1:0]       regs_q [NUM_REGS];
    logic [DW-1:0]       regs_d [NUM_REGS];
    logic [DW-1:0]       rd_count_q, rd_count_d;
    logic [DW-1:0]       wr_count_q, wr_count_d;
    logic [DW-1:0]       rdat_q, rdat_d;
    logic                addr_err_q, addr_err_d;
    logic [NUM_REGS-1:0] hit;
    addr_kind_e          kind;
    logic [DW-1:0]       rd_val;

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            hit[i] = (addr == AW'(BaseInt + i));
        end
        if (|hit) begin
            kind = AddrGen;
        end else if (addr == RD_CNT_ADDR) begin
            kind = AddrRdCnt;
        end else if (addr == WR_CNT_ADDR) begin
            kind = AddrWrCnt;
        end else begin
            kind = AddrNone;
        end
    end

    // Read mux sees pre-update state, so a same-cycle write is not visible.
    always_comb begin
        rd_val = '0;
        case (kind)
            AddrGen: begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (hit[i]) begin
                        rd_val = regs_q[i];
                    end
                end
            end
            AddrRdCnt: rd_val = rd_count_q;
            AddrWrCnt: rd_val = wr_count_q;
            default:   rd_val = '0;
        endcase
    end

    always_comb begin
        regs_d     = regs_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        rdat_d     = rdat_q;
        addr_err_d = addr_err_q;

        if (rd_stb) begin
            rdat_d     = rd_val;
            rd_count_d = rd_count_q + DW'(1);
            if (kind == AddrNone) begin
                addr_err_d = 1'b1;
            end
        end

        if (wr_stb) begin
            case (kind)
                AddrGen: begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (hit[i]) begin
                            regs_d[i] = wdat;
                        end
                    end
                    wr_count_d = wr_count_q + DW'(1);
                end
                AddrWrCnt: wr_count_d = '0;
                AddrRdCnt: wr_count_d = wr_count_q + DW'(1);
                default: begin
                    wr_count_d = wr_count_q + DW'(1);
                    addr_err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            rd_count_q <= '0;
            wr_count_q <= '0;
            rdat_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            rdat_q     <= rdat_d;
            addr_err_q <= addr_err_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs[g*DW +: DW] = regs_q[g];
    end

    assign rdat     = rdat_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed plus randomised bench for spi_reg_bank against a transaction-level model.
module tb_spi_reg_bank;

    localparam int unsigned DW = 96;
    localparam int unsigned NR = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            spi_re = 1'b0;
    logic            spi_we = 1'b0;
    logic [6:0]      addr = '0;
    logic [DW-1:0]   wdat = '0;
    logic [DW-1:0]   rdat;
    logic [NR*DW-1:0] regs;
    logic [DW-1:0]   rd_count;
    logic [DW-1:0]   wr_count;
    logic            rd_stb;
    logic            wr_stb;
    logic            addr_err;

    logic            s_re = 1'b0;
    logic            s_we = 1'b0;
    logic [6:0]      s_addr = '0;
    logic [7:0]      s_wdat = '0;
    logic [7:0]      s_rdat;
    logic [7:0]      s_regs;
    logic [7:0]      s_rd_count;
    logic [7:0]      s_wr_count;
    logic            s_rd_stb;
    logic            s_wr_stb;
    logic            s_addr_err;

    always #5 clk = ~clk;

    spi_reg_bank u_dut (
        .clk      (clk),
        .reset    (reset),
        .spi_re   (spi_re),
        .spi_we   (spi_we),
        .addr     (addr),
        .wdat     (wdat),
        .rdat     (rdat),
        .regs     (regs),
        .rd_count (rd_count),
        .wr_count (wr_count),
        .rd_stb   (rd_stb),
        .wr_stb   (wr_stb),
        .addr_err (addr_err)
    );

    spi_reg_bank #(
        .DW       (8),
        .NUM_REGS (1)
    ) u_dut_small (
        .clk      (clk),
        .reset    (reset),
        .spi_re   (s_re),
        .spi_we   (s_we),
        .addr     (s_addr),
        .wdat     (s_wdat),
        .rdat     (s_rdat),
        .regs     (s_regs),
        .rd_count (s_rd_count),
        .wr_count (s_wr_count),
        .rd_stb   (s_rd_stb),
        .wr_stb   (s_wr_stb),
        .addr_err (s_addr_err)
    );

    int rd_stb_cnt = 0;
    int wr_stb_cnt = 0;
    always @(negedge clk) begin
        if (rd_stb) rd_stb_cnt <= rd_stb_cnt + 1;
        if (wr_stb) wr_stb_cnt <= wr_stb_cnt + 1;
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [DW-1:0] m_regs [NR];
    logic [DW-1:0] m_rd, m_wr, m_rdat;
    logic          m_err;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_rd = '0; m_wr = '0; m_rdat = '0; m_err = 1'b0;
    endtask

    function automatic logic [DW-1:0] m_lookup(input logic [6:0] a);
        int ai = int'(a);
        if (ai >= 'h70 && ai < 'h70 + NR) return m_regs[ai - 'h70];
        if (ai == 'h7E) return m_rd;
        if (ai == 'h7F) return m_wr;
        return '0;
    endfunction

    // A read observes state from before any same-transaction write.
    task automatic model_apply(input bit rd, input bit wr, input logic [6:0] a,
                               input logic [DW-1:0] d);
        int ai = int'(a);
        bit mapped = (ai >= 'h70 && ai < 'h70 + NR) || ai == 'h7E || ai == 'h7F;
        if (rd) begin
            m_rdat = m_lookup(a);
            m_rd   = m_rd + 1;
            if (!mapped) m_err = 1'b1;
        end
        if (wr) begin
            if (ai >= 'h70 && ai < 'h70 + NR) m_regs[ai - 'h70] = d;
            if (ai == 'h7F) m_wr = '0;
            else m_wr = m_wr + 1;
            if (!mapped) m_err = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rdat"}, rdat, m_rdat);
        check({tag, ".rd_count"}, rd_count, m_rd);
        check({tag, ".wr_count"}, wr_count, m_wr);
        check({tag, ".addr_err"}, DW'(addr_err), DW'(m_err));
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s.reg%0d", tag, i), regs[i*DW +: DW], m_regs[i]);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b0; spi_re = 1'b0; spi_we = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [6:0] a, input logic [DW-1:0] d,
                       input string tag);
        int rs0 = rd_stb_cnt;
        int ws0 = wr_stb_cnt;
        @(posedge clk); #2;
        addr = a; wdat = d; spi_re = rd; spi_we = wr;
        repeat (5) @(posedge clk);
        #2 spi_re = 1'b0; spi_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_apply(rd, wr, a, d);
        check({tag, ".rd_stbs"}, DW'(rd_stb_cnt - rs0), DW'(rd));
        check({tag, ".wr_stbs"}, DW'(wr_stb_cnt - ws0), DW'(wr));
        check_all(tag);
    endtask

    task automatic stxn(input logic [7:0] d);
        @(posedge clk); #2;
        s_addr = 7'h70; s_wdat = d; s_we = 1'b1;
        repeat (4) @(posedge clk);
        #2 s_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int rs0;
        int ws0;
        bit rd, wr;
        int sel;
        logic [6:0] a;
        logic [DW-1:0] d;

        model_reset();
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // Request pulse of two clocks: one strobe, three edges after the rise.
        rs0 = rd_stb_cnt;
        lat = 0;
        @(posedge clk); #2;
        addr = 7'h70; spi_re = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (rd_stb && lat == 0) lat = k;
            if (k == 2) #1 spi_re = 1'b0;
        end
        check("rd_latency", DW'(lat), DW'(3));
        check("rd_single_stb", DW'(rd_stb_cnt - rs0), DW'(1));
        model_apply(1'b1, 1'b0, 7'h70, '0);
        check_all("pulse_read");

        do_reset();
        txn(1'b0, 1'b1, 7'h72, 'h1234, "wr_reg2");
        txn(1'b1, 1'b0, 7'h72, '0, "rd_reg2");
        check("rd_reg2_lit", rdat, 'h1234);
        check("rd_reg2_wr_count", wr_count, 1);
        check("rd_reg2_rd_count", rd_count, 1);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 1'b0, 7'h7E, '0, $sformatf("rdcnt%0d", i));
            check($sformatf("rdcnt%0d_lit", i), rdat, DW'(i));
        end
        check("rdcnt_total", rd_count, 3);
        for (int i = 0; i < 5; i++) txn(1'b0, 1'b1, 7'(7'h70 + i % NR), DW'(i + 1), "five_wr");
        check("five_wr_count", wr_count, 5);
        txn(1'b0, 1'b1, 7'h7F, 'hFFFF, "clr_wr");
        check("clr_wr_lit", wr_count, 0);

        txn(1'b1, 1'b0, 7'h10, '0, "unmapped_rd");
        check("unmapped_err", DW'(addr_err), DW'(1));
        check("unmapped_rdat", rdat, 0);
        txn(1'b1, 1'b0, 7'h71, '0, "valid_after_err");
        check("err_sticky", DW'(addr_err), DW'(1));

        do_reset();
        txn(1'b0, 1'b1, 7'h70, 'h55, "pre_55");
        txn(1'b1, 1'b1, 7'h70, 'hAA, "same_cycle");
        check("same_cycle_rdat", rdat, 'h55);
        check("same_cycle_reg0", regs[0 +: DW], 'hAA);
        txn(1'b1, 1'b1, 7'h7F, '0, "same_cycle_wrcnt");

        // Reset one clock after the write request rises drops the write.
        ws0 = wr_stb_cnt;
        @(posedge clk); #2;
        addr = 7'h71; wdat = 'hDEAD; spi_we = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0; spi_we = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        repeat (6) @(posedge clk);
        #1;
        check("midreset_no_stb", DW'(wr_stb_cnt - ws0), DW'(0));
        check_all("midreset");

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            rd = (sel != 1);
            wr = (sel != 0);
            if (rd && !wr && $urandom_range(0, 4) == 0) begin
                a = 7'($urandom_range(0, 'h6F));
            end else begin
                sel = $urandom_range(0, NR + 1);
                a = (sel < NR) ? 7'(7'h70 + sel) : (sel == NR ? 7'h7E : 7'h7F);
            end
            d = {$urandom, $urandom, $urandom};
            txn(rd, wr, a, d, $sformatf("rand%0d", n));
        end

        do_reset();
        for (int i = 0; i < 255; i++) stxn(8'(i));
        check("small_wr_255", DW'(s_wr_count), DW'(255));
        check("small_reg", DW'(s_regs), DW'(254));
        stxn(8'h5A);
        check("small_wrap", DW'(s_wr_count), DW'(0));
        check("small_reg_last", DW'(s_regs), DW'(8'h5A));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
